// File: rtl/revo_qualifier_encoder_flywheel_if.sv
// Revo qualifier bus: raw marker and fake enable in, strobes/word/status out.
// master = stimulus side, slave = qualifier side.
interface revo_qualifier_encoder_flywheel_if #(
  parameter int WIDTH = 8
);
  logic             rawtrg;
  logic             fake_enable;
  logic             revo;
  logic             revo_fake;
  logic [WIDTH-1:0] word;
  logic [1:0]       state;
  logic [15:0]      spurious_count;
  logic [15:0]      missing_count;

  modport master (
    output rawtrg, fake_enable,
    input  revo, revo_fake, word, state,
    input  spurious_count, missing_count
  );

  modport slave (
    input  rawtrg, fake_enable,
    output revo, revo_fake, word, state,
    output spurious_count, missing_count
  );
endinterface

// File: rtl/revo_qualifier_encoder_flywheel.sv
// Qualifies the raw revo marker (width, quiet gap, period window) and
// emits one real or flywheel revo per turn as a serdes word.
// Ports: clock, reset (async high), bus (slave): rawtrg, fake_enable in;
// revo, revo_fake, word, state, spurious_count, missing_count out.
module revo_qualifier_encoder_flywheel #(
  parameter int              WIDTH        = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD   = 8'hF0,
  parameter logic [WIDTH-1:0] REVO_WORD   = 8'hF2,
  parameter logic [WIDTH-1:0] FAKE_WORD   = 8'hF4,
  parameter int              MIN_DURATION = 1,
  parameter int              MAX_DURATION = 8,
  parameter int              GUARD        = 8,
  parameter int              REVO_PERIOD  = 1280,
  parameter int              TOLERANCE    = 2,
  parameter int              MISS_LIMIT   = 3
) (
  input logic clock,
  input logic reset,
  revo_qualifier_encoder_flywheel_if.slave bus
);

  localparam int CMAXI = REVO_PERIOD - 1 + TOLERANCE;
  localparam int CW = $clog2(CMAXI + 1);
  localparam int RW = $clog2(MAX_DURATION + 2);
  localparam int GW = $clog2(GUARD + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [CW-1:0] WIN_HI  = CW'(CMAXI);
  localparam logic [CW-1:0] WIN_LO  =
    CW'(REVO_PERIOD - 1 - TOLERANCE);
  localparam logic [CW-1:0] PER_END = CW'(REVO_PERIOD - 1);
  localparam logic [CW-1:0] TOL_C   = CW'(TOLERANCE);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DURATION + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GUARD);

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    LOCKED    = 2'd1,
    FREEWHEEL = 2'd2
  } state_t;

  logic s1_q, s2_q, s3_q;
  logic [RW-1:0] run_q, run_d;
  logic [GW-1:0] gap_q, gap_d;
  logic gok_q, gok_d;
  logic qual_q, qual;
  logic rise, fall;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] miss_q, miss_d;
  logic real_ev, fake_ev, spur_inc, miss_inc;

  logic revo_q, revo_d;
  logic fake_q, fake_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [15:0] spur_q, spur_d;
  logic [15:0] mcnt_q, mcnt_d;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_comb begin
    run_d = run_q;
    gap_d = gap_q;
    gok_d = gok_q;
    if (rise) begin
      run_d = RW'(1);
      gap_d = '0;
      gok_d = (gap_q == GAP_MAX);
    end else begin
      if (s2_q && run_q != RUN_MAX)
        run_d = run_q + RW'(1);
      if (!s2_q && gap_q != GAP_MAX)
        gap_d = gap_q + GW'(1);
    end
  end

  assign qual = fall & gok_q &
                (run_q >= RW'(MIN_DURATION)) &
                (run_q <= RW'(MAX_DURATION));

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == WIN_HI) ? cnt_q
                                 : cnt_q + CW'(1);
    miss_d   = miss_q;
    real_ev  = 1'b0;
    fake_ev  = 1'b0;
    spur_inc = 1'b0;
    miss_inc = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (qual_q) begin
          real_ev = 1'b1;
          cnt_d   = '0;
          miss_d  = '0;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (qual_q && cnt_q >= WIN_LO &&
            cnt_q <= WIN_HI) begin
          real_ev = 1'b1;
          cnt_d   = '0;
          miss_d  = '0;
        end else begin
          spur_inc = qual_q;
          if (cnt_q == WIN_HI) begin
            fake_ev  = 1'b1;
            miss_inc = 1'b1;
            // late fake re-centres on nominal phase
            cnt_d    = TOL_C;
            miss_d   = miss_q + MW'(1);
            if (miss_d == MW'(MISS_LIMIT)) begin
              state_d = FREEWHEEL;
              // keep the fake cadence at one period
              cnt_d   = '0;
            end
          end
        end
      end
      FREEWHEEL: begin
        if (qual_q) begin
          real_ev = 1'b1;
          cnt_d   = '0;
          miss_d  = '0;
          state_d = LOCKED;
        end else if (cnt_q == PER_END) begin
          fake_ev = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    fake_d = fake_ev & bus.fake_enable;
    revo_d = real_ev | fake_d;
    word_d = IDLE_WORD;
    if (fake_d)
      word_d = FAKE_WORD;
    else if (revo_d)
      word_d = REVO_WORD;
    spur_d = spur_q;
    if (spur_inc && spur_q != 16'hFFFF)
      spur_d = spur_q + 16'd1;
    mcnt_d = mcnt_q;
    if (miss_inc && mcnt_q != 16'hFFFF)
      mcnt_d = mcnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      run_q   <= '0;
      gap_q   <= '0;
      gok_q   <= 1'b0;
      qual_q  <= 1'b0;
      state_q <= SEARCH;
      cnt_q   <= '0;
      miss_q  <= '0;
      revo_q  <= 1'b0;
      fake_q  <= 1'b0;
      word_q  <= IDLE_WORD;
      spur_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      s1_q    <= bus.rawtrg;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      run_q   <= run_d;
      gap_q   <= gap_d;
      gok_q   <= gok_d;
      qual_q  <= qual;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      revo_q  <= revo_d;
      fake_q  <= fake_d;
      word_q  <= word_d;
      spur_q  <= spur_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign bus.revo           = revo_q;
  assign bus.revo_fake      = fake_q;
  assign bus.word           = word_q;
  assign bus.state          = state_q;
  assign bus.spurious_count = spur_q;
  assign bus.missing_count  = mcnt_q;

endmodule
